// File: rtl/hex_calc_pkg.sv
// rtl/hex_calc_pkg.sv - shared constants and FSM encoding for the hex calculator sequencer
package hex_calc_pkg;

  localparam int NIBBLE_W = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_addsub.sv
// rtl/nibble_addsub.sv - combinational 4-bit ripple-carry add/sub slice (b inverted when sub=1)
module nibble_addsub
  import hex_calc_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                sub,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  logic [NIBBLE_W:0]   c;
  logic [NIBBLE_W-1:0] bx;

  always_comb begin
    bx   = b ^ {NIBBLE_W{sub}};
    c    = '0;
    sum  = '0;
    c[0] = c_in;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    c_out = c[NIBBLE_W];
  end

endmodule

// File: rtl/hex_calc_seq.sv
// rtl/hex_calc_seq.sv - nibble-serial add/sub sequencer with valid/ready in and out
// Optional signed saturation on overflow when HEX_CALC_SEQ_SAT_EN is defined.
module hex_calc_seq
  import hex_calc_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      op,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                      carry,
  output logic                      overflow,
  output logic                      zero
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBBLES - 1);

  state_t             state;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic               op_r;
  logic [IDX_W-1:0]   idx;
  logic               c_r;

  logic [NIBBLE_W-1:0] a_nib;
  logic [NIBBLE_W-1:0] b_nib;
  logic [NIBBLE_W-1:0] sum;
  logic                c_out;
  logic [W-1:0]        res_next;
  logic [W-1:0]        res_final;
  logic                ovf_next;

  nibble_addsub u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .sub   (op_r),
    .c_in  (c_r),
    .sum   (sum),
    .c_out (c_out)
  );

  // Steer the current nibble into the slice and merge its sum back in place.
  always_comb begin
    a_nib    = '0;
    b_nib    = '0;
    res_next = result;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IDX_W'(n)) begin
        a_nib = a_r[n*NIBBLE_W +: NIBBLE_W];
        b_nib = b_r[n*NIBBLE_W +: NIBBLE_W];
        res_next[n*NIBBLE_W +: NIBBLE_W] = sum;
      end
    end
    ovf_next  = (a_r[W-1] == (b_r[W-1] ^ op_r)) && (sum[NIBBLE_W-1] != a_r[W-1]);
    res_final = res_next;
`ifdef HEX_CALC_SEQ_SAT_EN
    if (ovf_next) begin
      res_final = a_r[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      idx       <= '0;
      c_r       <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= op;
            c_r      <= (op == OP_SUB);
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          c_r <= c_out;
          if (idx == LAST) begin
            result    <= res_final;
            carry     <= c_out;
            overflow  <= ovf_next;
            zero      <= (res_final == '0);
            out_valid <= 1'b1;
            idx       <= '0;
            state     <= ST_DONE;
          end else begin
            result <= res_next;
            idx    <= idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/hex_calc_seq.md
Name: hex_calc_seq

Overview:
Multi-nibble add/subtract sequencer for the UART hex calculator. It accepts two NIBBLES-wide hex operands and an opcode through a valid/ready handshake, then processes one nibble per cycle (LSB first) through a single 4-bit ripple-carry add/sub slice, chaining the carry in a register. It returns the full-width result plus flags through a valid/ready output handshake. It sits between the UART command parser and the result formatter/transmitter.

Parameters:
NIBBLES, 4, operand/result width in hex digits (data width W = 4*NIBBLES); legal values 1..8.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operand/op request valid.
in_ready  output  1  block can accept a request (high only in IDLE).
op  input  1  0 = add (a+b), 1 = subtract (a-b).
a  input  W  operand A, unsigned/two's complement.
b  input  W  operand B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts result.
result  output  W  sum/difference, modulo 2^W.
carry  output  1  add: carry out; sub: 1 = no borrow (a>=b unsigned).
overflow  output  1  signed two's-complement overflow.
zero  output  1  result == 0.

Behaviour:
- Reset (async, active-high): state=IDLE, in_ready=1 once released, out_valid=0, result=0, carry=0, overflow=0, zero=0, nibble index=0, carry register=0.
- FSM states are IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid is high at a clock edge, latch a, b, op; set carry register = op (sub injects c_in=1, B inverted per nibble); index=0; go to RUN.
- RUN: in_ready=0. Each cycle the slice computes a[i], b[i]^{4{op}}, and the carry register. The sum nibble is written to result[4i+3:4i], the carry register takes c_out, and index increments. After nibble NIBBLES-1, go to DONE and set the flags:
  - carry = final c_out.
  - overflow = (a[W-1] == eb[W-1]) && (res[W-1] != a[W-1]), where eb = b ^ {W{op}}.
  - zero = (result == 0).
- DONE: out_valid=1. Outputs are held stable until out_ready is high at an edge, then go to IDLE with out_valid=0. Outputs keep their last values in IDLE.
- Latency: request accepted at edge T. out_valid rises after edge T+NIBBLES. Minimum request-to-request period is NIBBLES+2 cycles.
- in_valid during RUN/DONE is ignored and not queued. out_ready outside DONE is ignored.
- Back-pressure: DONE may hold indefinitely. result and flags must not change while out_valid=1.
- Reset asserted mid-RUN or mid-DONE: the operation is aborted, outputs return to reset values, and no partial result is presented.
- The index counter is sized clog2(NIBBLES) with a minimum of 1 bit. It never wraps past NIBBLES-1.

Optional Feature:
Macro: HEX_CALC_SEQ_SAT_EN.
- Defined: on signed overflow, result is clamped to the signed limit. Positive overflow (a sign 0) gives 0x7F..F. Negative overflow gives 0x80..0. The overflow flag is still reported, zero is computed on the clamped value, and carry is unchanged. Clamping is applied on the RUN->DONE transition, so latency is unchanged.
- Not defined: wrap-around result only, and the clamp logic is absent.

Decomposition:
- Package hex_calc_pkg holds:
  - NIBBLE_W=4.
  - Opcode constants OP_ADD=1'b0, OP_SUB=1'b1.
  - State encodings ST_IDLE/ST_RUN/ST_DONE.
- Natural sub-module: nibble_addsub, a combinational 4-bit slice with inputs a, b, sub, c_in and outputs sum, c_out. It inverts b when sub=1 and uses a ripple of 4 full adders. Exactly one instance.

Test Plan:
- NIBBLES=4, add 0x1234+0x0FFF, out_ready=1 -> result=0x2233, carry=0, overflow=0, zero=0; out_valid exactly 4 cycles after the accept edge.
- Sub 0x0003-0x0005 -> result=0xFFFE, carry=0 (borrow), overflow=0; then sub 0x0005-0x0003 -> 0x0002, carry=1.
- Add 0x7FFF+0x0001 -> result=0x8000, overflow=1. With HEX_CALC_SEQ_SAT_EN -> result=0x7FFF, overflow=1. Sub 0x8000-0x0001 with SAT -> 0x8000, overflow=1.
- Add 0xFFFF+0x0001 -> result=0x0000, carry=1, zero=1, overflow=0.
- Back-pressure: hold out_ready=0 for 10 cycles -> result/flags stable, in_ready=0, a second in_valid pulse is ignored; release out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst after 2 nibbles of 0x1111+0x2222 -> out_valid=0 and result=0 immediately (async); after release, a fresh 0x0001+0x0001 yields 0x0002.
